tone_sequencer: RTL and testbench



---
 rtl/tone_seq_pkg.sv | 9 +
 rtl/note_rom.sv | 14 +
 rtl/tone_sequencer.sv | 99 +++++++++
 tb/tb_tone_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared states, note width and pitch-to-divider table for tone_sequencer.
package tone_seq_pkg;
  localparam int NOTE_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;
  localparam logic [9:0] PITCH_N [16] = '{
    10'd0,   10'd758, 10'd675, 10'd637, 10'd568, 10'd506, 10'd477, 10'd425,
    10'd379, 10'd337, 10'd318, 10'd284, 10'd253, 10'd238, 10'd212, 10'd189
  };
endpackage

// File: rtl/note_rom.sv
// note_rom: synchronous 16x8 melody ROM, one-cycle read latency.
module note_rom
  import tone_seq_pkg::*;
#(
  parameter logic [16*NOTE_W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic [3:0]        addr,
  output logic [NOTE_W-1:0] data_q
);
  logic [NOTE_W-1:0] data_d;
  always_comb data_d = INIT[addr*NOTE_W +: NOTE_W];
  always_ff @(posedge clk) data_q <= data_d;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a ROM melody as N/volume for pwm_audio.
// Define TONE_SEQ_ENVELOPE_EN for a per-tick decaying volume envelope.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int TICK_DIV = 250000,
  parameter int SONG_LEN = 16,
  parameter logic [16*NOTE_W-1:0] ROM_INIT = 128'h11_D3_B1_92_73_51_32_13_F0_E2_C3_A1_82_63_41_23
`ifdef TONE_SEQ_ENVELOPE_EN
  , parameter logic [7:0] DECAY_STEP = 8'd4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] master_vol,
  output logic [9:0] N,
  output logic [7:0] volume,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_idx
);
  localparam int PW = $clog2(TICK_DIV);
  state_e state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0] dur_q, dur_d, idx_q, idx_d;
  logic [9:0] n_q, n_d;
  logic [7:0] vol_q, vol_d, rom_q;
  logic busy_q, busy_d, done_q, done_d, tick, last, sound;
  assign tick  = pre_q == PW'(TICK_DIV - 1);
  assign last  = idx_q == 4'(SONG_LEN - 1);
  assign sound = rom_q[7:4] != 4'd0;
  // addressed by the next index so the entry is already valid during LOAD
  note_rom #(.INIT(ROM_INIT)) u_rom (.clk(clk), .addr(idx_d), .data_q(rom_q));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: state_d = start && !stop ? LOAD : IDLE;
      LOAD: begin
        state_d = PLAY;
        dur_d   = rom_q[3:0];
      end
      PLAY: begin
        state_d = tick && dur_q == 4'd0 ? GAP : PLAY;
        dur_d   = tick && dur_q != 4'd0 ? dur_q - 4'd1 : dur_q;
      end
      GAP: if (tick) begin
        state_d = last ? IDLE : LOAD;
        idx_d   = last ? 4'd0 : idx_q + 4'd1;
        done_d  = last;
      end
    endcase
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      idx_d   = 4'd0;
      done_d  = 1'b0;
    end
    pre_d  = (state_q == PLAY || state_q == GAP) && !tick ? pre_q + 1'b1 : '0;
    busy_d = state_d != IDLE;
    n_d    = state_q == PLAY && sound ? PITCH_N[rom_q[7:4]] : n_q;
`ifdef TONE_SEQ_ENVELOPE_EN
    vol_d = state_q == LOAD ? (sound ? master_vol : 8'd0) :
            state_q == PLAY && state_d == PLAY ?
              (tick ? (vol_q > DECAY_STEP ? vol_q - DECAY_STEP : 8'd0) : vol_q) : 8'd0;
`else
    vol_d = state_q == PLAY && state_d == PLAY && sound ? master_vol : 8'd0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      dur_q   <= 4'd0;
      idx_q   <= 4'd0;
      n_q     <= 10'h3FF;
      vol_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      vol_q   <= vol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign N        = n_q;
  assign volume   = vol_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed checks of tone_sequencer with a short two-note bench melody.
module tb_tone_sequencer;
  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0;
  logic [7:0] mvol = 8'd128;
  logic [9:0] n_a, n_b;
  logic [7:0] vol_a, vol_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [3:0] idx_a, idx_b;
  int total = 0, bad = 0;
  logic [9:0] n_log [32];
  logic [7:0] vol_log [32];
  logic done_log [32], busy_log [32];
  logic [3:0] idx_log [32];
  always #5 clk = ~clk;
  tone_sequencer #(.TICK_DIV(4), .SONG_LEN(2), .ROM_INIT({112'h0, 8'h20, 8'h12})) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .master_vol(mvol),
    .N(n_a), .volume(vol_a), .busy(busy_a), .done(done_a), .note_idx(idx_a)
  );
  tone_sequencer #(.TICK_DIV(4), .SONG_LEN(2), .ROM_INIT({112'h0, 8'h20, 8'h03})) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(1'b0), .master_vol(mvol),
    .N(n_b), .volume(vol_b), .busy(busy_b), .done(done_b), .note_idx(idx_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // start sampled at edge k; returns at the negedge following edge k
  task automatic fire_a();
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
  endtask
  initial begin
    int cnt, cnt2;
    repeat (2) @(negedge clk);
    check("rst_n", 32'(n_a), 32'h3FF);
    check("rst_vol", 32'(vol_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_idx", 32'(idx_a), 0);
    rst = 1'b0;
    @(negedge clk);
    fire_a();
    for (int j = 0; j < 30; j++) begin
      n_log[j] = n_a; vol_log[j] = vol_a; done_log[j] = done_a;
      busy_log[j] = busy_a; idx_log[j] = idx_a;
      start_a = (j == 5);
      @(negedge clk);
    end
    check("busy_k", 32'(busy_log[0]), 1);
    check("vol_k1", 32'(vol_log[1]), 0);
    check("n_k2", 32'(n_log[2]), 758);
    check("vol_k2", 32'(vol_log[2]), 128);
    check("vol_k12", 32'(vol_log[12]), 128);
    check("vol_gap1", 32'(vol_log[13]), 0);
    check("idx_note2", 32'(idx_log[17]), 1);
    check("n_note2", 32'(n_log[19]), 675);
    check("vol_note2", 32'(vol_log[21]), 128);
    check("vol_gap2", 32'(vol_log[22]), 0);
    check("done_early", 32'(done_log[25]), 0);
    check("done_pulse", 32'(done_log[26]), 1);
    check("busy_end", 32'(busy_log[26]), 0);
    check("idx_end", 32'(idx_log[26]), 0);
    cnt = 0; cnt2 = 0;
    for (int j = 0; j < 30; j++) begin
      cnt  += (j < 19 && vol_log[j] == 8'd128) ? 1 : 0;
      cnt2 += done_log[j] ? 1 : 0;
    end
    check("note1_len", 32'(cnt), 11);
    check("done_count", 32'(cnt2), 1);
    fire_a();
    repeat (19) @(negedge clk);
    check("stop_pre_n", 32'(n_a), 675);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check("stop_busy", 32'(busy_a), 0);
    check("stop_vol", 32'(vol_a), 0);
    check("stop_idx", 32'(idx_a), 0);
    check("stop_n_hold", 32'(n_a), 675);
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      cnt += (done_a || busy_a) ? 1 : 0;
      @(negedge clk);
    end
    check("stop_no_done", 32'(cnt), 0);
    fire_a();
    check("replay_idx", 32'(idx_a), 0);
    check("replay_busy", 32'(busy_a), 1);
    repeat (2) @(negedge clk);
    check("replay_n", 32'(n_a), 758);
    check("replay_vol", 32'(vol_a), 128);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check("replay_stop", 32'(busy_a), 0);
    start_a = 1'b1; stop_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; stop_a = 1'b0;
    check("both_busy", 32'(busy_a), 0);
    @(negedge clk);
    check("both_busy2", 32'(busy_a), 0);
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int j = 0; j < 22; j++) begin
      cnt  += (j <= 20 && vol_b != 8'd0) ? 1 : 0;
      cnt2 += (j <= 20 && n_b != 10'h3FF) ? 1 : 0;
      if (j == 10) check("rest_busy", 32'(busy_b), 1);
      if (j == 20) check("rest_idx0", 32'(idx_b), 0);
      if (j == 21) check("rest_idx1", 32'(idx_b), 1);
      @(negedge clk);
    end
    check("rest_vol", 32'(cnt), 0);
    check("rest_n", 32'(cnt2), 0);
    fire_a();
    repeat (4) @(negedge clk);
    check("rst_pre_vol", 32'(vol_a), 128);
    rst = 1'b1;
    #1;
    check("arst_n", 32'(n_a), 32'h3FF);
    check("arst_vol", 32'(vol_a), 0);
    check("arst_busy", 32'(busy_a), 0);
    check("arst_idx", 32'(idx_a), 0);
    check("arst_done", 32'(done_a), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle", 32'(busy_a), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
